hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the combinational stall/flush hazard logic.
- Tracks pending register writes with per-register countdown scoreboards instead of comparing neighbouring stage payloads.
- Adds a multi-cycle functional unit (mul/div) with a structural interlock, plus a serialise/drain mode for CSR and fence instructions.
- Sits beside decode. Drives per-stage stall/flush vectors for an NSTAGE in-order pipeline. Stage 0 = fetch/PC, 1 = D, 2 = E, remaining stages follow.

Parameters:
- NREG, 32, architectural register count; register 0 is hard-wired zero and never tracked.
- NSTAGE, 5, pipeline stages (minimum 4); width of the stall/flush vectors.
- MAX_LAT, 7, largest fixed latency class accepted on issue_lat.
- LAT_W, $clog2(MAX_LAT+2), counter width; code MAX_LAT+1 is reserved as the "multi-cycle pending" sentinel.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- issue_valid  input  1  D holds a valid instruction.
- issue_rs1, issue_rs2  input  $clog2(NREG)  source registers.
- issue_dst  input  $clog2(NREG)  destination register.
- issue_wen  input  1  instruction writes issue_dst.
- issue_lat  input  LAT_W  cycles after issue until result is forwardable (0 = ALU, 1 = load).
- issue_mc  input  1  instruction uses the multi-cycle unit.
- issue_serial  input  1  CSR/fence: must issue into an empty pipeline.
- mc_done  input  1  multi-cycle unit completes this cycle.
- redirect  input  1  branch/jump resolved taken in E.
- trap  input  1  exception/mret/interrupt committing at the last stage.
- stall  output  NSTAGE  bit i holds the register feeding stage i.
- flush  output  NSTAGE  bit i clears the register feeding stage i.
- issue_fire  output  1  instruction in D advances to E this cycle.
- mc_busy  output  1  multi-cycle operation in flight.
- sb_empty  output  1  all counters zero and mc_busy low.

Behaviour:
- Reset (async, reset low):
  - Counters are 0 and the FSM is in RUN.
  - mc_busy = 0, sb_empty = 1.
  - stall, flush and issue_fire are 0 whenever issue_valid = 0 and trap = 0.
- Register outputs: mc_busy and the FSM state. stall, flush, issue_fire and sb_empty are combinational from state, counters and inputs.
- Counters: one cnt[r] per register r = 1..NREG-1.
  - Each cycle, any cnt that is non-zero and not the sentinel decrements by 1.
  - The sentinel holds until mc_done, then goes to 0 that same edge.
- Data hazard: issue_valid AND (rs1 != 0 AND cnt[rs1] != 0, OR rs2 != 0 AND cnt[rs2] != 0).
- Structural hazard: issue_valid AND issue_mc AND mc_busy AND NOT mc_done.
- Serial hazard: issue_valid AND issue_serial AND NOT sb_empty.
- Issue (issue_fire):
  - cnt[dst] is loaded with issue_lat, or with the sentinel if issue_mc. This load overrides the decrement when dst != 0 and wen = 1.
  - If issue_mc, mc_busy is set.
  - mc_done clears mc_busy unless a new multi-cycle op issues the same cycle.
- FSM states:
  - RUN: normal operation.
  - DRAIN: entered when a serial hazard is detected in RUN. Holds D until sb_empty, then issues and returns to RUN.
  - TRAPFLUSH: entered on trap from any state. Lasts one cycle, then RUN.
- Priority, first match wins:
  1. trap: flush all bits, stall = 0. All counters and mc_busy are cleared at the edge (the squashed multi-cycle result is discarded). Next state is TRAPFLUSH.
  2. redirect: flush[1] and flush[2] set, stall = 0. issue_fire = 0, so the D instruction does not write the scoreboard.
  3. Any hazard (data, structural, serial): stall[0] and stall[1] set, flush[2] set (bubble into E), issue_fire = 0.
  4. Otherwise: issue_fire = issue_valid.
- In TRAPFLUSH, issue_fire = 0 and flush[1] = 1, so a wrong-path fetch is dropped.
- Reads of register 0 never hazard. Writes to register 0 are never tracked.
- Simultaneous mc_done and a read of the sentinel register: the hazard is still raised that cycle; the dependent instruction issues next cycle.
- The decrement saturates at 0. The counter never wraps.

Decomposition:
- Package pipeline:
  - hsb_state_t enum (RUN, DRAIN, TRAPFLUSH).
  - Stage index constants STG_F = 0, STG_D = 1, STG_E = 2.
  - Function for the sentinel value.
- One sub-module, hsb_counter: a single-register countdown with load, sentinel hold, clear and done. It is instantiated NREG-1 times by generate.

Test Plan:
- Load then dependent use: issue x5 with lat = 1, next cycle a read of x5. Expect 1 stall cycle, stall = 5'b00011, flush = 5'b00100, then issue_fire.
- Multi-cycle: a div writes x7, mc_done arrives 6 cycles later, and a dependent instruction on x7 follows. Expect stalls until mc_done, issue the cycle after, and mc_busy 1 → 0 on the done edge.
- Structural: a second issue_mc while mc_busy. Expect a stall. The second op issues on the cycle mc_done is asserted, and mc_busy stays 1.
- Serialise: a CSR op arrives with cnt[x3] = 2. Expect DRAIN for 2 cycles, then issue_fire, then RUN.
- Trap during a hazard: trap while a load-use stall and mc_busy are active. Expect flush = 5'b11111, stall = 0, all counters 0, mc_busy = 0, and the next cycle flush[1] = 1.
- Reset mid-operation: pull reset low with the sentinel pending. Expect all outputs at their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the pipeline hazard scoreboard.
package hazard_scoreboard_pkg;

    // Control FSM: normal issue, draining for a serialising op, one cycle after a trap.
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DRAIN     = 2'd1,
        TRAPFLUSH = 2'd2
    } hsb_state_t;

    // Stage indices into the stall/flush vectors.
    localparam int STG_F = 0;
    localparam int STG_D = 1;
    localparam int STG_E = 2;

    // Counter code reserved for "waiting on the multi-cycle unit".
    function automatic int unsigned hsb_sentinel(input int unsigned max_lat);
        return max_lat + 1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_hsb_counter.sv
// One register's countdown: load on issue, decrement to zero, or hold the
// multi-cycle sentinel until the unit reports completion. Clear wins over all.
module hsb_counter #(
    parameter int              LAT_W = 4,
    parameter logic [LAT_W-1:0] SENT = '1
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [LAT_W-1:0] load_val_i,
    input  logic             done_i,
    output logic [LAT_W-1:0] cnt_o
);

    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] cnt_d;

    // Next count: clear > load > sentinel hold/release > saturating decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q == SENT) begin
            if (done_i) begin
                cnt_d = '0;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - LAT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based hazard unit sitting beside decode. Tracks pending writes
// with per-register countdowns, interlocks the multi-cycle unit, serialises
// CSR/fence ops, and drives per-stage stall/flush for an in-order pipeline.
//
// Handshake: issue_valid says D holds an instruction; issue_fire is the
// acceptance. An instruction moves D->E (and updates the scoreboard) only in
// a cycle where issue_valid and issue_fire are both high; otherwise it is
// held in D (stall) or squashed (flush) and must be presented again.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREG    = 32,
    parameter int NSTAGE  = 5,
    parameter int MAX_LAT = 7,
    parameter int LAT_W   = $clog2(MAX_LAT + 2)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  logic [$clog2(NREG)-1:0]  issue_rs1,
    input  logic [$clog2(NREG)-1:0]  issue_rs2,
    input  logic [$clog2(NREG)-1:0]  issue_dst,
    input  logic                     issue_wen,
    input  logic [LAT_W-1:0]         issue_lat,
    input  logic                     issue_mc,
    input  logic                     issue_serial,
    input  logic                     mc_done,
    input  logic                     redirect,
    input  logic                     trap,
    output logic [NSTAGE-1:0]        stall,
    output logic [NSTAGE-1:0]        flush,
    output logic                     issue_fire,
    output logic                     mc_busy,
    output logic                     sb_empty,
    output hsb_state_t               state_o
);

    localparam int               REG_W = $clog2(NREG);
    localparam logic [LAT_W-1:0] SENT  = LAT_W'(hsb_sentinel(MAX_LAT));

    hsb_state_t       state_q, state_d;
    logic             mc_busy_q, mc_busy_d;
    logic [LAT_W-1:0] cnt [NREG];
    logic [LAT_W-1:0] load_val;
    logic             any_pend;
    logic             data_haz, struct_haz, serial_haz, any_haz;

    assign load_val = issue_mc ? SENT : issue_lat;

    // Register 0 is hard-wired zero and is never tracked.
    assign cnt[0] = '0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        hsb_counter #(
            .LAT_W (LAT_W),
            .SENT  (SENT)
        ) u_cnt (
            .clk        (clk),
            .rst_ni     (reset),
            .clear_i    (trap),
            .load_i     (issue_fire & issue_wen & (issue_dst == REG_W'(r))),
            .load_val_i (load_val),
            .done_i     (mc_done),
            .cnt_o      (cnt[r])
        );
    end

    // Scoreboard is empty when no write is pending and the multi-cycle unit is idle.
    always_comb begin
        any_pend = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            any_pend = any_pend | (cnt[r] != '0);
        end
        sb_empty = ~any_pend & ~mc_busy_q;
    end

    // Hazard detection for the instruction sitting in D.
    always_comb begin
        data_haz   = issue_valid &
                     (((issue_rs1 != '0) && (cnt[issue_rs1] != '0)) ||
                      ((issue_rs2 != '0) && (cnt[issue_rs2] != '0)));
        struct_haz = issue_valid & issue_mc & mc_busy_q & ~mc_done;
        serial_haz = issue_valid & issue_serial & ~sb_empty;
        any_haz    = data_haz | struct_haz | serial_haz;
    end

    // Pipeline control and FSM next state, first matching rule wins.
    always_comb begin
        stall      = '0;
        flush      = '0;
        issue_fire = 1'b0;
        state_d    = RUN;
        if (trap) begin
            flush   = '1;
            state_d = TRAPFLUSH;
        end else if (state_q == TRAPFLUSH) begin
            // Drop the wrong-path fetch that followed the trap.
            flush[STG_D] = 1'b1;
        end else if (redirect) begin
            flush[STG_D] = 1'b1;
            flush[STG_E] = 1'b1;
        end else if (any_haz) begin
            stall[STG_F] = 1'b1;
            stall[STG_D] = 1'b1;
            flush[STG_E] = 1'b1;
            state_d      = serial_haz ? DRAIN : RUN;
        end else begin
            issue_fire = issue_valid;
        end
    end

    // Multi-cycle busy flag: a new op in the done cycle keeps it set.
    always_comb begin
        mc_busy_d = mc_busy_q;
        if (trap) begin
            mc_busy_d = 1'b0;
        end else if (issue_fire && issue_mc) begin
            mc_busy_d = 1'b1;
        end else if (mc_done) begin
            mc_busy_d = 1'b0;
        end
    end

    // State and busy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            mc_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mc_busy_q <= mc_busy_d;
        end
    end

    assign mc_busy = mc_busy_q;
    assign state_o = state_q;

endmodule
